vedic_mul_pipe: RTL and testbench

VEDIC_MUL_PIPE -- requirements
Module: vedic_mul_pipe

---
 rtl/vedic_pkg.sv | 22 ++
 rtl/vedic_pipe_reg.sv | 25 ++
 rtl/vedic_mul_pipe.sv | 205 ++++++++++++++++++++
 tb/tb_vedic_mul_pipe.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vedic_pkg.sv
// Shared constants and helpers for the pipelined Vedic multiplier.
package vedic_pkg;

  localparam int unsigned LATENCY          = 4;
  localparam int unsigned NUM_LEGAL_WIDTHS = 3;
  localparam int unsigned LEGAL_WIDTHS [NUM_LEGAL_WIDTHS] = '{16, 32, 64};

  // Full product width for a given operand width.
  function automatic int unsigned prod_w(input int unsigned w);
    return 2 * w;
  endfunction

  function automatic bit width_is_legal(input int unsigned w);
    bit ok;
    ok = 1'b0;
    for (int unsigned i = 0; i < NUM_LEGAL_WIDTHS; i++) begin
      if (LEGAL_WIDTHS[i] == w) ok = 1'b1;
    end
    return ok;
  endfunction

endpackage

// File: rtl/vedic_pipe_reg.sv
// One pipeline stage: payload register plus valid bit, frozen while en is low.
module vedic_pipe_reg #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         in_valid,
  input  logic [W-1:0] d,
  output logic         out_valid,
  output logic [W-1:0] q
);

  // Payload only loads with valid data so bubbles leave the register quiet.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      q         <= '0;
    end else if (en) begin
      out_valid <= in_valid;
      if (in_valid) q <= d;
    end
  end

endmodule

// File: rtl/vedic_mul_pipe.sv
// Four-stage WIDTH x WIDTH multiplier built from half-width partial products.
// Define VEDIC_SIGNED_EN to honour is_signed (sign-magnitude around the core).
module vedic_mul_pipe
  import vedic_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WIDTH-1:0]            a,
  input  logic [WIDTH-1:0]            b,
  input  logic                        is_signed,
  input  logic [TAG_W-1:0]            in_tag,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [prod_w(WIDTH)-1:0]    product,
  output logic [TAG_W-1:0]            out_tag
);

  localparam int unsigned H          = WIDTH / 2;
  localparam int unsigned MW         = WIDTH + 2;
  localparam int unsigned PW         = prod_w(WIDTH);
  localparam int unsigned NUM_STAGES = 4;

  if (!width_is_legal(WIDTH) || NUM_STAGES != LATENCY) begin : g_bad_cfg
    $error("vedic_mul_pipe: unsupported WIDTH or stage count");
  end

  typedef struct packed {
    logic [WIDTH-1:0] hh;
    logic [WIDTH-1:0] lh;
    logic [WIDTH-1:0] hl;
    logic [WIDTH-1:0] ll;
`ifdef VEDIC_SIGNED_EN
    logic             neg;
`endif
    logic [TAG_W-1:0] tag;
  } s1_t;

  typedef struct packed {
    logic [MW-1:0]    mid;
    logic [WIDTH-1:0] hh;
    logic [WIDTH-1:0] ll;
`ifdef VEDIC_SIGNED_EN
    logic             neg;
`endif
    logic [TAG_W-1:0] tag;
  } s2_t;

  typedef struct packed {
    logic [MW-1:0]    mid2;
    logic [WIDTH-1:0] hh;
    logic [WIDTH-1:0] ll;
`ifdef VEDIC_SIGNED_EN
    logic             neg;
`endif
    logic [TAG_W-1:0] tag;
  } s3_t;

  typedef struct packed {
    logic [PW-1:0]    prod;
    logic [TAG_W-1:0] tag;
  } s4_t;

  logic stall;
  logic adv;
  logic in_fire;

  s1_t  s1_d, s1_q;
  s2_t  s2_d, s2_q;
  s3_t  s3_d, s3_q;
  s4_t  s4_d, s4_q;
  logic s1_v, s2_v, s3_v, s4_v;

  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] upper;
  logic [PW-1:0]    full;

  // The whole pipe freezes while a finished product waits for the consumer.
  assign stall    = s4_v && !out_ready;
  assign adv      = !stall;
  assign in_ready = !stall && !reset;
  assign in_fire  = in_valid && in_ready;

`ifdef VEDIC_SIGNED_EN
  logic neg_in;

  // Signed operands enter the unsigned core as magnitudes; -2^(W-1) maps to 2^(W-1).
  always_comb begin
    a_mag  = a;
    b_mag  = b;
    neg_in = 1'b0;
    if (is_signed) begin
      if (a[WIDTH-1]) a_mag = ~a + WIDTH'(1);
      if (b[WIDTH-1]) b_mag = ~b + WIDTH'(1);
      neg_in = a[WIDTH-1] ^ b[WIDTH-1];
    end
  end
`else
  logic unused_is_signed;

  assign unused_is_signed = is_signed;
  assign a_mag            = a;
  assign b_mag            = b;
`endif

  // S1: four half-width partial products.
  always_comb begin
    s1_d     = '0;
    s1_d.hh  = WIDTH'(a_mag[WIDTH-1:H]) * WIDTH'(b_mag[WIDTH-1:H]);
    s1_d.lh  = WIDTH'(a_mag[H-1:0])     * WIDTH'(b_mag[WIDTH-1:H]);
    s1_d.hl  = WIDTH'(a_mag[WIDTH-1:H]) * WIDTH'(b_mag[H-1:0]);
    s1_d.ll  = WIDTH'(a_mag[H-1:0])     * WIDTH'(b_mag[H-1:0]);
`ifdef VEDIC_SIGNED_EN
    s1_d.neg = neg_in;
`endif
    s1_d.tag = in_tag;
  end

  // S2: sum of the cross terms, kept two bits wider than WIDTH.
  always_comb begin
    s2_d     = '0;
    s2_d.mid = MW'(s1_q.lh) + MW'(s1_q.hl);
    s2_d.hh  = s1_q.hh;
    s2_d.ll  = s1_q.ll;
`ifdef VEDIC_SIGNED_EN
    s2_d.neg = s1_q.neg;
`endif
    s2_d.tag = s1_q.tag;
  end

  // S3: fold the upper half of the low product into the middle column.
  always_comb begin
    s3_d      = '0;
    s3_d.mid2 = s2_q.mid + MW'(s2_q.ll[WIDTH-1:H]);
    s3_d.hh   = s2_q.hh;
    s3_d.ll   = s2_q.ll;
`ifdef VEDIC_SIGNED_EN
    s3_d.neg  = s2_q.neg;
`endif
    s3_d.tag  = s3_d.tag;
    s3_d.tag  = s2_q.tag;
  end

  // S4: final assembly; the upper sum cannot overflow WIDTH bits for a true product.
  always_comb begin
    upper = s3_q.hh + WIDTH'(s3_q.mid2[MW-1:H]);
    full  = {upper, s3_q.mid2[H-1:0], s3_q.ll[H-1:0]};
`ifdef VEDIC_SIGNED_EN
    if (s3_q.neg) full = ~full + PW'(1);
`endif
    s4_d      = '0;
    s4_d.prod = full;
    s4_d.tag  = s3_q.tag;
  end

  vedic_pipe_reg #(.W($bits(s1_t))) u_s1 (
    .clk       (clk),
    .reset     (reset),
    .en        (adv),
    .in_valid  (in_fire),
    .d         (s1_d),
    .out_valid (s1_v),
    .q         (s1_q)
  );

  vedic_pipe_reg #(.W($bits(s2_t))) u_s2 (
    .clk       (clk),
    .reset     (reset),
    .en        (adv),
    .in_valid  (s1_v),
    .d         (s2_d),
    .out_valid (s2_v),
    .q         (s2_q)
  );

  vedic_pipe_reg #(.W($bits(s3_t))) u_s3 (
    .clk       (clk),
    .reset     (reset),
    .en        (adv),
    .in_valid  (s2_v),
    .d         (s3_d),
    .out_valid (s3_v),
    .q         (s3_q)
  );

  vedic_pipe_reg #(.W($bits(s4_t))) u_s4 (
    .clk       (clk),
    .reset     (reset),
    .en        (adv),
    .in_valid  (s3_v),
    .d         (s4_d),
    .out_valid (s4_v),
    .q         (s4_q)
  );

  assign out_valid = s4_v;
  assign product   = s4_q.prod;
  assign out_tag   = s4_q.tag;

endmodule

// File: tb/tb_vedic_mul_pipe.sv
// Directed bench for vedic_mul_pipe at WIDTH 32 (main), 16 (signed cases) and 64.
module tb_vedic_mul_pipe;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int total_cnt = 0;
  int pass_cnt  = 0;

  logic        v32 = 0, ir32, ov32, or32 = 0, s32 = 0;
  logic [31:0] a32 = 0, b32 = 0;
  logic [3:0]  t32 = 0, ot32;
  logic [63:0] p32;

  logic        v16 = 0, ir16, ov16, or16 = 0, s16 = 0;
  logic [15:0] a16 = 0, b16 = 0;
  logic [3:0]  t16 = 0, ot16;
  logic [31:0] p16;

  logic         v64 = 0, ir64, ov64, or64 = 0, s64 = 0;
  logic [63:0]  a64 = 0, b64 = 0;
  logic [3:0]   t64 = 0, ot64;
  logic [127:0] p64;

  vedic_mul_pipe #(.WIDTH(32), .TAG_W(4)) dut32 (
    .clk(clk), .reset(reset), .in_valid(v32), .in_ready(ir32), .a(a32), .b(b32),
    .is_signed(s32), .in_tag(t32), .out_valid(ov32), .out_ready(or32),
    .product(p32), .out_tag(ot32));

  vedic_mul_pipe #(.WIDTH(16), .TAG_W(4)) dut16 (
    .clk(clk), .reset(reset), .in_valid(v16), .in_ready(ir16), .a(a16), .b(b16),
    .is_signed(s16), .in_tag(t16), .out_valid(ov16), .out_ready(or16),
    .product(p16), .out_tag(ot16));

  vedic_mul_pipe #(.WIDTH(64), .TAG_W(4)) dut64 (
    .clk(clk), .reset(reset), .in_valid(v64), .in_ready(ir64), .a(a64), .b(b64),
    .is_signed(s64), .in_tag(t64), .out_valid(ov64), .out_ready(or64),
    .product(p64), .out_tag(ot64));

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    total_cnt++;
    if (ov32 !== 1'b0 || p32 !== 64'd0 || ot32 !== 4'd0)
      $display("FAIL reset_state: ov=%b p=%h tag=%h, required 0/0/0", ov32, p32, ot32);
    else pass_cnt++;
    total_cnt++;
    if (ir32 !== 1'b0) $display("FAIL reset_in_ready: got %b required 0", ir32);
    else pass_cnt++;
    reset = 1'b0;
    #1;
    total_cnt++;
    if (ir32 !== 1'b1) $display("FAIL in_ready_after_reset: got %b required 1", ir32);
    else pass_cnt++;
  endtask

  task automatic test_max_product;
    int lat;
    lat = 0;
    or32 = 1'b1;
    v32 = 1'b1; a32 = 32'hFFFF_FFFF; b32 = 32'hFFFF_FFFF; t32 = 4'd3;
    for (int i = 1; i <= 10 && lat == 0; i++) begin
      @(negedge clk);
      v32 = 1'b0;
      if (ov32 === 1'b1) lat = i;
    end
    total_cnt++;
    if (lat !== 4) $display("FAIL max_latency: got %0d cycles required 4", lat);
    else pass_cnt++;
    total_cnt++;
    if (p32 !== 64'hFFFF_FFFE_0000_0001) $display("FAIL max_product: got %h required fffffffe00000001", p32);
    else pass_cnt++;
    total_cnt++;
    if (ot32 !== 4'd3) $display("FAIL max_tag: got %0d required 3", ot32);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    logic [63:0] exp_p [8];
    int got, gap;
    exp_p = '{64'd3, 64'd6, 64'd9, 64'd12, 64'd15, 64'd18, 64'd21, 64'd24};
    got = 0; gap = 0;
    or32 = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i < 8) begin
        v32 = 1'b1; a32 = 32'(i + 1); b32 = 32'd3; t32 = 4'(i + 1);
      end else v32 = 1'b0;
      @(negedge clk);
      if (ov32 === 1'b1) begin
        if (got < 8) begin
          total_cnt++;
          if (p32 !== exp_p[got] || ot32 !== 4'(got + 1))
            $display("FAIL b2b_result%0d: got %0d tag %0d required %0d tag %0d", got, p32, ot32, exp_p[got], got + 1);
          else pass_cnt++;
        end
        got++;
      end else if (got > 0 && got < 8) gap++;
    end
    total_cnt++;
    if (got !== 8 || gap !== 0) $display("FAIL b2b_count: got %0d results with %0d gaps, required 8 and 0", got, gap);
    else pass_cnt++;
  endtask

  task automatic test_stall;
    logic [63:0] exp_p [5];
    logic [63:0] held;
    int issued, recv, cycles, held_bad, ir_bad, held_seen, extra;
    logic acc, xfer;
    exp_p = '{64'd70, 64'd77, 64'd84, 64'd91, 64'd98};
    issued = 0; recv = 0; cycles = 0; held_bad = 0; ir_bad = 0; held_seen = 0; extra = 0;
    held = '0;
    or32 = 1'b0;
    v32 = 1'b1; a32 = 32'd10; b32 = 32'd7; t32 = 4'd0;
    while (recv < 5 && cycles < 40) begin
      #1;
      acc  = v32 && ir32;
      xfer = ov32 && or32;
      if (ov32 === 1'b1 && or32 === 1'b0) begin
        if (ir32 !== 1'b0) ir_bad++;
        if (held_seen == 0) held = p32;
        else if (p32 !== held) held_bad++;
        held_seen++;
      end
      if (xfer) begin
        total_cnt++;
        if (p32 !== exp_p[recv] || ot32 !== 4'(recv))
          $display("FAIL stall_result%0d: got %0d tag %0d required %0d tag %0d", recv, p32, ot32, exp_p[recv], recv);
        else pass_cnt++;
        recv++;
      end
      @(negedge clk);
      cycles++;
      if (acc) issued++;
      if (issued < 5) begin
        v32 = 1'b1; a32 = 32'(10 + issued); t32 = 4'(issued);
      end else v32 = 1'b0;
      or32 = (cycles >= 6);
    end
    repeat (6) begin
      @(negedge clk);
      if (ov32 !== 1'b0) extra++;
    end
    total_cnt++;
    if (recv !== 5 || extra !== 0) $display("FAIL stall_count: got %0d results plus %0d extra, required 5 and 0", recv, extra);
    else pass_cnt++;
    total_cnt++;
    if (held_seen < 2 || held_bad !== 0) $display("FAIL stall_hold: %0d held cycles, %0d changes, required >=2 and 0", held_seen, held_bad);
    else pass_cnt++;
    total_cnt++;
    if (ir_bad !== 0) $display("FAIL stall_in_ready: high on %0d stalled cycles, required 0", ir_bad);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    int seen;
    seen = 0;
    or32 = 1'b1;
    v32 = 1'b1; a32 = 32'd5; b32 = 32'd5; t32 = 4'd1;
    @(negedge clk);
    if (ov32 !== 1'b0) seen++;
    a32 = 32'd6; t32 = 4'd2;
    @(negedge clk);
    if (ov32 !== 1'b0) seen++;
    a32 = 32'd7; t32 = 4'd3;
    @(negedge clk);
    if (ov32 !== 1'b0) seen++;
    v32 = 1'b0;
    reset = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (ov32 !== 1'b0) seen++;
    end
    reset = 1'b0;
    #1;
    total_cnt++;
    if (ir32 !== 1'b1 || p32 !== 64'd0) $display("FAIL reset_mid_release: in_ready %b product %h, required 1 and 0", ir32, p32);
    else pass_cnt++;
    repeat (10) begin
      @(negedge clk);
      if (ov32 !== 1'b0) seen++;
    end
    total_cnt++;
    if (seen !== 0) $display("FAIL reset_mid_flush: out_valid on %0d cycles, required 0", seen);
    else pass_cnt++;
  endtask

  task automatic test_w16_signed;
    logic [15:0] av [5];
    logic [15:0] bv [5];
    logic        sv [5];
    logic [31:0] ev [5];
    int issued, recv, cycles;
    logic acc, xfer;
    av = '{16'h8000, 16'h8000, 16'h8000, 16'hFFFD, 16'hFFFD};
    bv = '{16'hFFFF, 16'hFFFF, 16'h8000, 16'h0005, 16'h0005};
    sv = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
`ifdef VEDIC_SIGNED_EN
    ev = '{32'h0000_8000, 32'h7FFF_8000, 32'h4000_0000, 32'hFFFF_FFF1, 32'h0004_FFF1};
`else
    ev = '{32'h7FFF_8000, 32'h7FFF_8000, 32'h4000_0000, 32'h0004_FFF1, 32'h0004_FFF1};
`endif
    issued = 0; recv = 0; cycles = 0;
    or16 = 1'b1;
    v16 = 1'b1; a16 = av[0]; b16 = bv[0]; s16 = sv[0]; t16 = 4'd0;
    while (recv < 5 && cycles < 40) begin
      #1;
      acc  = v16 && ir16;
      xfer = ov16 && or16;
      if (xfer) begin
        total_cnt++;
        if (p16 !== ev[recv] || ot16 !== 4'(recv))
          $display("FAIL w16_result%0d: got %h tag %0d required %h tag %0d", recv, p16, ot16, ev[recv], recv);
        else pass_cnt++;
        recv++;
      end
      @(negedge clk);
      cycles++;
      if (acc) issued++;
      if (issued < 5) begin
        v16 = 1'b1; a16 = av[issued]; b16 = bv[issued]; s16 = sv[issued]; t16 = 4'(issued);
      end else v16 = 1'b0;
    end
    total_cnt++;
    if (recv !== 5) $display("FAIL w16_count: got %0d results required 5", recv);
    else pass_cnt++;
  endtask

  task automatic test_w64;
    logic [63:0]  av [7];
    logic [63:0]  bv [7];
    logic [127:0] ev [7];
    int issued, recv, cycles;
    logic acc, xfer;
    av = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 64'h0000_0001_0000_0001,
           64'h0123_4567_89AB_CDEF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000,
           64'h0000_0000_FFFF_FFFF};
    bv = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0002, 64'h0000_0001_0000_0001,
           64'h0, 64'h1, 64'h8000_0000_0000_0000, 64'h0000_0000_FFFF_FFFF};
    ev = '{128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001,
           128'h0000_0000_0000_0001_0000_0000_0000_0000,
           128'h0000_0000_0000_0001_0000_0002_0000_0001,
           128'h0,
           128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF,
           128'h4000_0000_0000_0000_0000_0000_0000_0000,
           128'h0000_0000_0000_0000_FFFF_FFFE_0000_0001};
    issued = 0; recv = 0; cycles = 0;
    s64 = 1'b0;
    or64 = 1'($urandom_range(0, 1));
    v64 = 1'b1; a64 = av[0]; b64 = bv[0]; t64 = 4'd0;
    while (recv < 7 && cycles < 200) begin
      #1;
      acc  = v64 && ir64;
      xfer = ov64 && or64;
      if (xfer) begin
        total_cnt++;
        if (p64 !== ev[recv] || ot64 !== 4'(recv))
          $display("FAIL w64_result%0d: got %h tag %0d required %h tag %0d", recv, p64, ot64, ev[recv], recv);
        else pass_cnt++;
        recv++;
      end
      @(negedge clk);
      cycles++;
      if (acc) issued++;
      if (issued < 7) begin
        v64 = 1'b1; a64 = av[issued]; b64 = bv[issued]; t64 = 4'(issued);
      end else v64 = 1'b0;
      or64 = 1'($urandom_range(0, 1));
    end
    total_cnt++;
    if (recv !== 7) $display("FAIL w64_count: got %0d results required 7", recv);
    else pass_cnt++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_max_product();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_w16_signed();
    test_w64();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
